// File: rtl/ram_block_mover.sv
// ram_block_mover: single-master COPY/FILL block engine for a ram_8-style single-port memory
module ram_block_mover #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic [WIDTH-1:0]      fill_value,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_in,
  output logic                  mem_load,
  input  logic [WIDTH-1:0]      mem_out
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, next;
  logic                  fill_q;
  logic [ADDR_WIDTH-1:0] src_p, dst_p, addr_hold;
  logic [ADDR_WIDTH:0]   rem;
  logic [WIDTH-1:0]      data_q, fill_v, in_hold;
  logic                  last_word;
  assign last_word = rem == {{ADDR_WIDTH{1'b0}}, 1'b1};
  // state register
  always_ff @(posedge clock)
    state <= reset ? IDLE : next;
  // next state: one read then one write per word for COPY, one write per word for FILL
  always_comb begin
    next = IDLE;
    next = state == IDLE  ? (start ? (count == '0 ? DONE : (mode ? WRITE : READ)) : IDLE) :
           state == READ  ? WRITE :
           state == WRITE ? (last_word ? DONE : (fill_q ? WRITE : READ)) : IDLE;
  end
  // command latch, pointers, remaining count, read data and held bus values
  always_ff @(posedge clock)
    if (reset) begin
      fill_q    <= 1'b0;
      src_p     <= '0;
      dst_p     <= '0;
      rem       <= '0;
      data_q    <= '0;
      fill_v    <= '0;
      addr_hold <= '0;
      in_hold   <= '0;
    end else begin
      addr_hold <= mem_addr;
      in_hold   <= mem_in;
      if (state == IDLE && start) begin
        fill_q <= mode;
        src_p  <= src_base;
        dst_p  <= dst_base;
        rem    <= count;
        fill_v <= fill_value;
      end
      if (state == READ) data_q <= mem_out;
      if (state == WRITE) begin
        src_p <= src_p + 1'b1;
        dst_p <= dst_p + 1'b1;
        rem   <= rem - 1'b1;
      end
    end
  assign mem_addr = state == READ ? src_p : state == WRITE ? dst_p : addr_hold;
  assign mem_in   = state == WRITE ? (fill_q ? fill_v : data_q) : in_hold;
  assign mem_load = (state == WRITE) & ~reset;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
endmodule

// File: tb/tb_ram_block_mover.sv
// tb_ram_block_mover: randomized and directed checks of ram_block_mover against an array-level model
module tb_ram_block_mover;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0;
  logic [2:0]  src_base = '0, dst_base = '0;
  logic [3:0]  count = '0;
  logic [15:0] fill_value = '0;
  logic        busy, done, mem_load;
  logic [2:0]  mem_addr;
  logic [15:0] mem_in, mem_out;
  logic [15:0] ram [8];
  logic [15:0] model [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_a = '0;
  logic [15:0] pre_d = '0;
  int n_chk = 0, n_fail = 0;

  ram_block_mover #(.WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .src_base(src_base), .dst_base(dst_base), .count(count), .fill_value(fill_value),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_load(mem_load), .mem_out(mem_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (mem_load) ram[mem_addr] <= mem_in;
    else if (pre_we) ram[pre_a] <= pre_d;
  assign mem_out = ram[mem_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clock);
    pre_we = 1'b0;
    model[a] = d;
  endtask

  task automatic check_ram();
    for (int i = 0; i < 8; i++) check($sformatf("ram[%0d]", i), 64'(ram[i]), 64'(model[i]));
  endtask

  task automatic run_cmd(input logic m, input logic [2:0] s, input logic [2:0] d,
                         input logic [3:0] n, input logic [15:0] f, input logic poke);
    int lat, dones, busys, first_done;
    logic [63:0] loads, exp_loads;
    lat = n == 0 ? 1 : (m ? int'(n) + 1 : 2 * int'(n) + 1);
    exp_loads = '0;
    for (int i = 0; i < int'(n); i++) exp_loads[6'(m ? i + 1 : 2 * i + 2)] = 1'b1;
    start = 1'b1; mode = m; src_base = s; dst_base = d; count = n; fill_value = f;
    @(negedge clock);
    start = 1'b0; mode = ~m; src_base = 3'($urandom); dst_base = 3'($urandom);
    count = 4'($urandom_range(1, 8)); fill_value = 16'($urandom);
    loads = '0; dones = 0; busys = 0; first_done = 0;
    for (int c = 1; c <= lat + 3; c++) begin
      loads[6'(c)] = mem_load;
      if (done) begin
        dones++;
        if (first_done == 0) first_done = c;
      end
      if (busy) busys++;
      start = poke && c <= lat && (c == 2 || c == lat);
      @(negedge clock);
    end
    start = 1'b0;
    check("done_cycle", 64'(first_done), 64'(lat));
    check("done_pulses", 64'(dones), 64'd1);
    check("busy_cycles", 64'(busys), 64'(lat));
    check("load_pattern", loads, exp_loads);
    for (int i = 0; i < int'(n); i++)
      model[3'(int'(d) + i)] = m ? f : model[3'(int'(s) + i)];
    check_ram();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_load", 64'(mem_load), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_in", 64'(mem_in), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
    run_cmd(1'b1, 3'd0, 3'd2, 4'd3, 16'hBEEF, 1'b0);
    for (int i = 0; i < 8; i++) preload(3'(i), 16'(16'h0100 + i));
    run_cmd(1'b0, 3'd0, 3'd4, 4'd4, 16'h0, 1'b0);
    run_cmd(1'b1, 3'd0, 3'd6, 4'd4, 16'h1234, 1'b0);
    run_cmd(1'b0, 3'd1, 3'd2, 4'd0, 16'h5555, 1'b0);
    run_cmd(1'b1, 3'd3, 3'd5, 4'd0, 16'h6666, 1'b0);
    run_cmd(1'b1, 3'd0, 3'd3, 4'd8, 16'hC0DE, 1'b0);
    preload(3'd0, 16'hAAAA);
    run_cmd(1'b0, 3'd0, 3'd1, 4'd3, 16'h0, 1'b1);
    for (int i = 0; i < 8; i++) preload(3'(i), 16'(16'h0100 + i));
    start = 1'b1; mode = 1'b0; src_base = 3'd0; dst_base = 3'd4; count = 4'd4;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_rst_load", 64'(mem_load), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_cycle_load", 64'(mem_load), 64'd0);
    check("rst_cycle_done", 64'(done), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_addr", 64'(mem_addr), 64'd0);
    model[4] = 16'h0100;
    for (int c = 0; c < 3; c++) begin
      check("post_rst_done", 64'(done), 64'd0);
      @(negedge clock);
    end
    check_ram();
    run_cmd(1'b0, 3'd5, 3'd1, 4'd2, 16'h0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) == 0) preload(3'($urandom), 16'($urandom));
      run_cmd(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom),
              4'($urandom_range(0, 8)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
